// File: rtl/kernel_kcore_start_fifo_mc.sv
// kernel_kcore_start_fifo_mc: NUM_CH independent shift-register start/token FIFOs with
// occupancy count, almost-full/almost-empty flags and per-channel flush.
module kernel_kcore_start_fifo_mc #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            flush,
    input  logic [NUM_CH-1:0]            if_write_ce,
    input  logic [NUM_CH-1:0]            if_write,
    input  logic [NUM_CH*DATA_WIDTH-1:0] if_din,
    output logic [NUM_CH-1:0]            if_full_n,
    output logic [NUM_CH-1:0]            if_almost_full,
    input  logic [NUM_CH-1:0]            if_read_ce,
    input  logic [NUM_CH-1:0]            if_read,
    output logic [NUM_CH*DATA_WIDTH-1:0] if_dout,
    output logic [NUM_CH-1:0]            if_empty_n,
    output logic [NUM_CH-1:0]            if_almost_empty,
    output logic [NUM_CH*CNT_W-1:0]      if_count
);
    genvar k;
    for (k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] head;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  empty_n_q, full_n_q, af_q, ae_q, wr_acc, rd_acc;
        assign wr_acc = if_write[k] & if_write_ce[k] & full_n_q;
        assign rd_acc = if_read[k] & if_read_ce[k] & empty_n_q;
        always_comb cnt_d = (reset | flush[k]) ? '0 :
                            (wr_acc & ~rd_acc) ? cnt_q + CNT_W'(1) :
                            (rd_acc & ~wr_acc) ? cnt_q - CNT_W'(1) : cnt_q;
        // Newest word sits in slot 0, so the oldest lives at slot count-1.
        always_comb begin
            head = mem_q[0];
            for (int i = 1; i < DEPTH; i++) head = (cnt_q == CNT_W'(i + 1)) ? mem_q[i] : head;
        end
        always_ff @(posedge clk) begin
            cnt_q     <= cnt_d;
            empty_n_q <= cnt_d != '0;
            full_n_q  <= cnt_d != CNT_W'(DEPTH);
            af_q      <= int'(cnt_d) >= DEPTH - AF_MARGIN;
            ae_q      <= int'(cnt_d) <= AE_MARGIN;
            if (wr_acc && !reset) begin
                mem_q[0] <= if_din[k*DATA_WIDTH +: DATA_WIDTH];
                for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
            end
        end
        assign if_dout[k*DATA_WIDTH +: DATA_WIDTH] = head;
        assign if_count[k*CNT_W +: CNT_W]          = cnt_q;
        assign if_empty_n[k]                       = empty_n_q;
        assign if_full_n[k]                        = full_n_q;
        assign if_almost_full[k]                   = af_q;
        assign if_almost_empty[k]                  = ae_q;
    end
endmodule

// File: tb/tb_kernel_kcore_start_fifo_mc.sv
// tb_kernel_kcore_start_fifo_mc: scoreboard bench for a DEPTH=4/1-bit and a DEPTH=5/4-bit instance.
module tb_kernel_kcore_start_fifo_mc;
    logic clk = 1'b0, reset = 1'b0;
    logic [1:0] fl4 = '0, wce4 = '1, wr4 = '0, rce4 = '1, rd4 = '0, din4 = '0;
    logic [1:0] dout4, full_n4, af4, empty_n4, ae4;
    logic [5:0] cnt4;
    logic [1:0] fl5 = '0, wce5 = '1, wr5 = '0, rce5 = '1, rd5 = '0;
    logic [7:0] din5 = '0, dout5;
    logic [1:0] full_n5, af5, empty_n5, ae5;
    logic [5:0] cnt5;
    int checks = 0, errors = 0;
    int mc [4];
    logic [3:0] sb [4][$];

    always #5 clk = ~clk;

    kernel_kcore_start_fifo_mc #(.DATA_WIDTH(1), .DEPTH(4), .NUM_CH(2)) d4 (
        .clk(clk), .reset(reset), .flush(fl4), .if_write_ce(wce4), .if_write(wr4), .if_din(din4),
        .if_full_n(full_n4), .if_almost_full(af4), .if_read_ce(rce4), .if_read(rd4), .if_dout(dout4),
        .if_empty_n(empty_n4), .if_almost_empty(ae4), .if_count(cnt4));

    kernel_kcore_start_fifo_mc #(.DATA_WIDTH(4), .DEPTH(5), .NUM_CH(2)) d5 (
        .clk(clk), .reset(reset), .flush(fl5), .if_write_ce(wce5), .if_write(wr5), .if_din(din5),
        .if_full_n(full_n5), .if_almost_full(af5), .if_read_ce(rce5), .if_read(rd5), .if_dout(dout5),
        .if_empty_n(empty_n5), .if_almost_empty(ae5), .if_count(cnt5));

    function automatic logic [2:0] cnt_of(input int d, input int ch);
        return d ? cnt5[ch*3 +: 3] : cnt4[ch*3 +: 3];
    endfunction

    // {empty_n, full_n, almost_full, almost_empty}
    function automatic logic [3:0] flags_of(input int d, input int ch);
        return d ? {empty_n5[ch], full_n5[ch], af5[ch], ae5[ch]} : {empty_n4[ch], full_n4[ch], af4[ch], ae4[ch]};
    endfunction

    function automatic logic [3:0] exp_flags(input int d, input int c);
        int dep = d ? 5 : 4;
        return {c != 0, c != dep, c >= dep - 1, c <= 1};
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 4; i++) begin
            mc[i] = 0;
            sb[i].delete();
        end
    endfunction

    // Drives one cycle on one channel; pushes accepted writes, pops the word an accepted read should see.
    task automatic step(input int d, input int ch, input bit wr, input logic [3:0] wd, input bit rd, input bit fl,
                        output logic [3:0] got, output bit rok, output logic [3:0] exp);
        int dep = d ? 5 : 4;
        int q = d * 2 + ch;
        bit wok;
        logic [3:0] w;
        w = d ? wd : {3'b000, wd[0]};
        got = d ? dout5[ch*4 +: 4] : {3'b000, dout4[ch]};
        exp = 'x;
        wok = wr && mc[q] < dep;
        rok = rd && mc[q] > 0 && !fl;
        if (d == 0) begin
            wr4[ch] = wr; din4[ch] = w[0]; rd4[ch] = rd; fl4[ch] = fl;
        end else begin
            wr5[ch] = wr; din5[ch*4 +: 4] = w; rd5[ch] = rd; fl5[ch] = fl;
        end
        if (fl) begin
            mc[q] = 0;
            sb[q].delete();
        end else begin
            if (rok) exp = sb[q].pop_front();
            if (wok) sb[q].push_back(w);
            mc[q] += int'(wok) - int'(rok);
        end
        @(posedge clk); #1;
        wr4 = '0; rd4 = '0; fl4 = '0; wr5 = '0; rd5 = '0; fl5 = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) begin
                checks++;
                if (cnt_of(d, ch) !== 3'd0) begin
                    errors++; $display("FAIL reset_count d%0d ch%0d got %0d exp 0", d, ch, cnt_of(d, ch));
                end
                checks++;
                if (flags_of(d, ch) !== 4'b0101) begin
                    errors++; $display("FAIL reset_flags d%0d ch%0d got %b exp 0101", d, ch, flags_of(d, ch));
                end
            end
    endtask

    task automatic test_fill;
        int vals [4] = '{1, 0, 1, 1};
        logic [3:0] got, exp;
        bit rok;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1'b1, 4'(vals[i]), 1'b0, 1'b0, got, rok, exp);
            checks++;
            if (cnt_of(0, 0) !== 3'(i + 1) || flags_of(0, 0) !== exp_flags(0, i + 1)) begin
                errors++; $display("FAIL fill_%0d got cnt %0d flags %b exp cnt %0d flags %b", i, cnt_of(0, 0), flags_of(0, 0), i + 1, exp_flags(0, i + 1));
            end
        end
        step(0, 0, 1'b1, 4'd0, 1'b0, 1'b0, got, rok, exp);
        checks++;
        if (cnt_of(0, 0) !== 3'd4 || flags_of(0, 0) !== 4'b1010) begin
            errors++; $display("FAIL fill_drop got cnt %0d flags %b exp cnt 4 flags 1010", cnt_of(0, 0), flags_of(0, 0));
        end
    endtask

    task automatic test_drain;
        logic [3:0] got, exp;
        bit rok;
        rce4[0] = 1'b0; rd4[0] = 1'b1;
        @(posedge clk); #1;
        rd4[0] = 1'b0; rce4[0] = 1'b1;
        checks++;
        if (cnt_of(0, 0) !== 3'd4) begin
            errors++; $display("FAIL read_ce_gate got cnt %0d exp 4", cnt_of(0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
            checks++;
            if (!rok || got !== exp || cnt_of(0, 0) !== 3'(3 - i)) begin
                errors++; $display("FAIL drain_%0d got dout %h cnt %0d exp dout %h cnt %0d", i, got, cnt_of(0, 0), exp, 3 - i);
            end
        end
        step(0, 0, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
        checks++;
        if (cnt_of(0, 0) !== 3'd0 || flags_of(0, 0) !== 4'b0101) begin
            errors++; $display("FAIL empty_read got cnt %0d flags %b exp cnt 0 flags 0101", cnt_of(0, 0), flags_of(0, 0));
        end
        wce4[0] = 1'b0; wr4[0] = 1'b1;
        @(posedge clk); #1;
        wr4[0] = 1'b0; wce4[0] = 1'b1;
        checks++;
        if (cnt_of(0, 0) !== 3'd0) begin
            errors++; $display("FAIL write_ce_gate got cnt %0d exp 0", cnt_of(0, 0));
        end
    endtask

    task automatic test_depth5;
        logic [3:0] got, exp;
        bit rok;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1'b1, 4'($urandom_range(15)), 1'b0, 1'b0, got, rok, exp);
            checks++;
            if (cnt_of(1, 1) !== 3'(i + 1) || flags_of(1, 1) !== exp_flags(1, i + 1)) begin
                errors++; $display("FAIL d5_fill_%0d got cnt %0d flags %b exp cnt %0d flags %b", i, cnt_of(1, 1), flags_of(1, 1), i + 1, exp_flags(1, i + 1));
            end
        end
        step(1, 1, 1'b1, 4'hF, 1'b0, 1'b0, got, rok, exp);
        checks++;
        if (cnt_of(1, 1) !== 3'd5 || flags_of(1, 1) !== 4'b1010) begin
            errors++; $display("FAIL d5_full got cnt %0d flags %b exp cnt 5 flags 1010", cnt_of(1, 1), flags_of(1, 1));
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
            checks++;
            if (!rok || got !== exp || cnt_of(1, 1) !== 3'(4 - i)) begin
                errors++; $display("FAIL d5_drain_%0d got dout %h cnt %0d exp dout %h cnt %0d", i, got, cnt_of(1, 1), exp, 4 - i);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] got, exp;
        bit rok;
        step(1, 0, 1'b1, 4'hA, 1'b0, 1'b0, got, rok, exp);
        step(1, 0, 1'b1, 4'hB, 1'b0, 1'b0, got, rok, exp);
        step(1, 0, 1'b1, 4'hC, 1'b1, 1'b0, got, rok, exp);
        checks++;
        if (!rok || got !== 4'hA || exp !== 4'hA || cnt_of(1, 0) !== 3'd2) begin
            errors++; $display("FAIL simul_mid got dout %h cnt %0d exp dout a cnt 2", got, cnt_of(1, 0));
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
            checks++;
            if (!rok || got !== exp) begin
                errors++; $display("FAIL simul_drain_%0d got %h exp %h", i, got, exp);
            end
        end
        for (int i = 1; i <= 5; i++) step(1, 0, 1'b1, 4'(i), 1'b0, 1'b0, got, rok, exp);
        step(1, 0, 1'b1, 4'hF, 1'b1, 1'b0, got, rok, exp);
        checks++;
        if (!rok || got !== 4'h1 || cnt_of(1, 0) !== 3'd4) begin
            errors++; $display("FAIL simul_full got dout %h cnt %0d exp dout 1 cnt 4", got, cnt_of(1, 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
            checks++;
            if (!rok || got !== exp) begin
                errors++; $display("FAIL simul_full_drain_%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_flush;
        logic [3:0] got, exp;
        bit rok;
        step(0, 0, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(0, 0, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(0, 0, 1'b1, 4'd0, 1'b0, 1'b0, got, rok, exp);
        step(0, 1, 1'b1, 4'd0, 1'b0, 1'b0, got, rok, exp);
        step(0, 1, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(0, 0, 1'b1, 4'd1, 1'b0, 1'b1, got, rok, exp);
        checks++;
        if (cnt_of(0, 0) !== 3'd0 || flags_of(0, 0) !== 4'b0101) begin
            errors++; $display("FAIL flush_ch0 got cnt %0d flags %b exp cnt 0 flags 0101", cnt_of(0, 0), flags_of(0, 0));
        end
        checks++;
        if (cnt_of(0, 1) !== 3'd2 || flags_of(0, 1) !== 4'b1100) begin
            errors++; $display("FAIL flush_ch1 got cnt %0d flags %b exp cnt 2 flags 1100", cnt_of(0, 1), flags_of(0, 1));
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
            checks++;
            if (!rok || got !== exp) begin
                errors++; $display("FAIL flush_ch1_drain_%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] got, exp;
        bit rok;
        step(0, 0, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(0, 1, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(1, 0, 1'b1, 4'h3, 1'b0, 1'b0, got, rok, exp);
        step(1, 0, 1'b1, 4'h7, 1'b0, 1'b0, got, rok, exp);
        reset = 1'b1; wr4[0] = 1'b1; din4[0] = 1'b0; rd4[1] = 1'b1; wr5[1] = 1'b1; rd5[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; wr4 = '0; rd4 = '0; wr5 = '0; rd5 = '0;
        clear_model();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) begin
                checks++;
                if (cnt_of(d, ch) !== 3'd0 || flags_of(d, ch) !== 4'b0101) begin
                    errors++; $display("FAIL reset_mid d%0d ch%0d got cnt %0d flags %b exp cnt 0 flags 0101", d, ch, cnt_of(d, ch), flags_of(d, ch));
                end
            end
        step(0, 1, 1'b1, 4'd1, 1'b0, 1'b0, got, rok, exp);
        step(0, 1, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
        checks++;
        if (!rok || got !== 4'd1) begin
            errors++; $display("FAIL reset_mid_rw4 got %h exp 1", got);
        end
        step(1, 1, 1'b1, 4'h9, 1'b0, 1'b0, got, rok, exp);
        step(1, 1, 1'b0, 4'd0, 1'b1, 1'b0, got, rok, exp);
        checks++;
        if (!rok || got !== 4'h9) begin
            errors++; $display("FAIL reset_mid_rw5 got %h exp 9", got);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_depth5();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
